// File: rtl/seq_divider_pkg.sv
// Shared execute-stage types plus the divider's state, flag and sign helpers.
package seq_divider_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MAX_W = 64;

  typedef logic [XLEN-1:0] regval_t;
  typedef logic [4:0]      regind_t;
  typedef regval_t [31:0]  regfile_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic div_by_zero;
    logic has_overflow;
  } div_flags_t;

  typedef logic [MAX_W-1:0] wide_t;

  // Callers pass an already sign- or zero-extended value; the MSB is the sign.
  function automatic wide_t abs_val(input wide_t value, input logic is_signed);
    return (is_signed && value[MAX_W-1]) ? wide_t'(-value) : value;
  endfunction

  function automatic wide_t apply_sign(input wide_t value, input logic negate);
    return negate ? wide_t'(-value) : value;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result handshake bundle between the pipeline and the divide unit.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_hold;
  logic             is_signed;
  logic [WIDTH-1:0] numer;
  logic [WIDTH-1:0] denom;
  logic             flush;
  logic             out_valid;
  logic             out_hold;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             has_overflow;

  modport master (
    output in_valid, is_signed, numer, denom, flush, out_hold,
    input  in_hold, out_valid, quotient, remainder, div_by_zero, has_overflow
  );

  modport slave (
    input  in_valid, is_signed, numer, denom, flush, out_hold,
    output in_hold, out_valid, quotient, remainder, div_by_zero, has_overflow
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module seq_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign shifted         = {part_rem, bit_in};
  assign {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit           = ~borrow;
  // Partial remainder stays below the divisor, so WIDTH bits always suffice.
  assign next_rem        = WIDTH'(q_bit ? diff : shifted);

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider resolving BITS_PER_CYCLE quotient bits per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic          clock,
  input logic          reset_n,
  seq_divider_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [1:0]  S_IDLE = IDLE;
  localparam logic [1:0]  S_RUN  = RUN;
  localparam logic [1:0]  S_DONE = DONE;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 4 || WIDTH > MAX_W || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("seq_divider: WIDTH must be 4..64 and a multiple of BITS_PER_CYCLE");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  div_flags_t       flags_q, flags_d;
  logic             take;

  // Accept-side operand preparation
  wide_t            numer_ext, denom_ext;
  logic [WIDTH-1:0] numer_mag, denom_mag;
  logic             denom_zero, signed_ovf;

  assign numer_ext  = bus.is_signed ? wide_t'(signed'(bus.numer)) : wide_t'(bus.numer);
  assign denom_ext  = bus.is_signed ? wide_t'(signed'(bus.denom)) : wide_t'(bus.denom);
  assign numer_mag  = WIDTH'(abs_val(numer_ext, bus.is_signed));
  assign denom_mag  = WIDTH'(abs_val(denom_ext, bus.is_signed));
  assign denom_zero = (bus.denom == '0);
  assign signed_ovf = bus.is_signed && (bus.numer == MOST_NEG) && (bus.denom == '1);

  // Chain of restoring steps; step 0 consumes the most significant pending bit
  logic [WIDTH-1:0]          chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qbits;
  logic [WIDTH-1:0]          rem_step, quo_step;

  assign chain[0] = rem_q;
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem (chain[k]),
      .divisor  (dvsr_q),
      .bit_in   (quo_q[WIDTH-1-k]),
      .next_rem (chain[k+1]),
      .q_bit    (qbits[BITS_PER_CYCLE-1-k])
    );
  end
  assign rem_step = chain[BITS_PER_CYCLE];
  assign quo_step = (quo_q << BITS_PER_CYCLE) | WIDTH'(qbits);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    flags_d     = flags_q;
    take        = 1'b0;

    case (state_q)
      S_IDLE: take = bus.in_valid;
      S_RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          quotient_d  = WIDTH'(apply_sign(wide_t'(quo_step), q_neg_q));
          remainder_d = WIDTH'(apply_sign(wide_t'(rem_step), r_neg_q));
          flags_d     = '0;
        end
      end
      S_DONE: begin
        if (!bus.out_hold) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          take        = bus.in_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take && !bus.flush) begin
      if (denom_zero) begin
        state_d              = S_DONE;
        out_valid_d          = 1'b1;
        quotient_d           = '1;
        remainder_d          = bus.numer;
        flags_d.div_by_zero  = 1'b1;
        flags_d.has_overflow = 1'b1;
      end else if (signed_ovf) begin
        state_d              = S_DONE;
        out_valid_d          = 1'b1;
        quotient_d           = bus.numer;
        remainder_d          = '0;
        flags_d.div_by_zero  = 1'b0;
        flags_d.has_overflow = 1'b1;
      end else begin
        state_d     = S_RUN;
        out_valid_d = 1'b0;
        cnt_d       = CNT_W'(STEPS);
        rem_d       = '0;
        quo_d       = numer_mag;
        dvsr_d      = denom_mag;
        q_neg_d     = bus.is_signed & (bus.numer[WIDTH-1] ^ bus.denom[WIDTH-1]);
        r_neg_d     = bus.is_signed & bus.numer[WIDTH-1];
      end
    end

    if (bus.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_hold      = (state_q == S_RUN) || ((state_q == S_DONE) && bus.out_hold);
  assign bus.out_valid    = out_valid_q;
  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;
  assign bus.div_by_zero  = flags_q.div_by_zero;
  assign bus.has_overflow = flags_q.has_overflow;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  seq_divider_if #(.WIDTH(32)) b32 ();
  seq_divider_if #(.WIDTH(16)) b16 ();

  seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .bus(b32.slave)
  );
  seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .bus(b16.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        s_valid, s_hold, s_dz, s_ov;
  logic [31:0] s_q, s_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the architectural special cases
  task automatic ref_div(input int w, input logic [31:0] n, input logic [31:0] d, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov);
    longint mask, nn, dd;
    mask = (longint'(1) << w) - 1;
    nn = longint'(n) & mask;
    dd = longint'(d) & mask;
    if (sgn && nn[w-1]) nn = nn - (longint'(1) << w);
    if (sgn && dd[w-1]) dd = dd - (longint'(1) << w);
    dz = 1'b0;
    ov = 1'b0;
    if (dd == 0) begin
      q = 32'(mask); r = 32'(longint'(n) & mask); dz = 1'b1; ov = 1'b1;
    end else if (sgn && nn == -(longint'(1) << (w - 1)) && dd == -1) begin
      q = 32'(longint'(n) & mask); r = 32'd0; ov = 1'b1;
    end else begin
      q = 32'((nn / dd) & mask);
      r = 32'((nn % dd) & mask);
    end
  endtask

  task automatic drive(input bit w16, input logic v, input logic [31:0] n, input logic [31:0] d,
                       input logic sgn);
    if (w16) begin
      b16.in_valid = v; b16.numer = n[15:0]; b16.denom = d[15:0]; b16.is_signed = sgn;
    end else begin
      b32.in_valid = v; b32.numer = n; b32.denom = d; b32.is_signed = sgn;
    end
  endtask

  task automatic grab(input bit w16);
    if (w16) begin
      s_valid = b16.out_valid; s_hold = b16.in_hold; s_dz = b16.div_by_zero;
      s_ov = b16.has_overflow; s_q = 32'(b16.quotient); s_r = 32'(b16.remainder);
    end else begin
      s_valid = b32.out_valid; s_hold = b32.in_hold; s_dz = b32.div_by_zero;
      s_ov = b32.has_overflow; s_q = b32.quotient; s_r = b32.remainder;
    end
  endtask

  // Called at a falling edge while the unit can accept; returns at the falling edge showing the result
  task automatic do_op(input bit w16, input logic [31:0] n, input logic [31:0] d, input logic sgn,
                       output int lat, output int holds);
    drive(w16, 1'b1, n, d, sgn);
    lat = 0;
    holds = 0;
    do begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 1) drive(w16, 1'b0, n, d, sgn);
      grab(w16);
      if (s_hold) holds++;
    end while (!s_valid && lat < 100);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] n, input logic [31:0] d,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input logic eov, input int elat);
    int lat, holds;
    do_op(1'b0, n, d, sgn, lat, holds);
    check({tag, "_valid"}, 64'(s_valid), 64'd1);
    check({tag, "_q"}, 64'(s_q), 64'(eq));
    check({tag, "_r"}, 64'(s_r), 64'(er));
    check({tag, "_dz"}, 64'(s_dz), 64'(edz));
    check({tag, "_ov"}, 64'(s_ov), 64'(eov));
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_holds"}, 64'(holds), 64'(elat - 1));
  endtask

  task automatic rand_op(input string tag, input bit w16);
    logic [31:0] n, d, eq, er;
    logic sgn, edz, eov;
    int lat, holds, steps, sel;
    sgn = 1'($urandom_range(0, 1));
    n = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0)      d = 32'd0;
    else if (sel <= 3) d = $urandom_range(1, 15);
    else if (sel == 4) d = 32'hFFFF_FFFF;
    else               d = $urandom >> $urandom_range(0, 31);
    if (sel == 4 && $urandom_range(0, 1) == 1) n = w16 ? 32'h8000 : 32'h8000_0000;
    if (w16) begin n = n & 32'hFFFF; d = d & 32'hFFFF; end
    ref_div(w16 ? 16 : 32, n, d, sgn, eq, er, edz, eov);
    steps = w16 ? 4 : 32;
    do_op(w16, n, d, sgn, lat, holds);
    check({tag, "_valid"}, 64'(s_valid), 64'd1);
    check({tag, "_q"}, 64'(s_q), 64'(eq));
    check({tag, "_r"}, 64'(s_r), 64'(er));
    check({tag, "_flags"}, 64'({s_dz, s_ov}), 64'({edz, eov}));
    check({tag, "_lat"}, 64'(lat), 64'((edz || eov) ? 1 : steps + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, holds, seen;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    b32.flush = 1'b0; b32.out_hold = 1'b0;
    b16.flush = 1'b0; b16.out_hold = 1'b0;

    #12;
    grab(1'b0);
    check("rst_valid", 64'(s_valid), 64'd0);
    check("rst_q", 64'(s_q), 64'd0);
    check("rst_r", 64'(s_r), 64'd0);
    check("rst_flags", 64'({s_dz, s_ov}), 64'd0);
    check("rst_in_hold", 64'(s_hold), 64'd0);
    grab(1'b1);
    check("rst16_valid", 64'(s_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_vec("u100_7",   32'd100,         32'd7,          1'b0, 32'd14,          32'd2,          1'b0, 1'b0, 33);
    run_vec("s-7_2",    32'hFFFF_FFF9,   32'd2,          1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF,  1'b0, 1'b0, 33);
    run_vec("uF9_2",    32'hFFFF_FFF9,   32'd2,          1'b0, 32'h7FFF_FFFC,   32'd1,          1'b0, 1'b0, 33);
    run_vec("u5_0",     32'd5,           32'd0,          1'b0, 32'hFFFF_FFFF,   32'd5,          1'b1, 1'b1, 1);
    run_vec("s5_0",     32'd5,           32'd0,          1'b1, 32'hFFFF_FFFF,   32'd5,          1'b1, 1'b1, 1);
    run_vec("s_ovf",    32'h8000_0000,   32'hFFFF_FFFF,  1'b1, 32'h8000_0000,   32'd0,          1'b0, 1'b1, 1);
    run_vec("u_msb",    32'h8000_0000,   32'hFFFF_FFFF,  1'b0, 32'd0,           32'h8000_0000,  1'b0, 1'b0, 33);

    // Downstream stall freezes the result, then a back-to-back accept on release
    do_op(1'b0, 32'd50, 32'd5, 1'b0, lat, holds);
    b32.out_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      grab(1'b0);
      check("hold_valid", 64'(s_valid), 64'd1);
      check("hold_q", 64'(s_q), 64'd10);
      check("hold_r", 64'(s_r), 64'd0);
      check("hold_in_hold", 64'(s_hold), 64'd1);
    end
    b32.out_hold = 1'b0;
    run_vec("b2b20_3", 32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0, 1'b0, 33);

    // Asynchronous reset in the middle of an operation
    drive(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
    #2 reset_n = 1'b0;
    #1 grab(1'b0);
    check("arst_q", 64'(s_q), 64'd0);
    check("arst_r", 64'(s_r), 64'd0);
    check("arst_valid", 64'(s_valid), 64'd0);
    check("arst_in_hold", 64'(s_hold), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_vec("post_rst", 32'd77, 32'd10, 1'b0, 32'd7, 32'd7, 1'b0, 1'b0, 33);

    // Flush ten cycles into a running divide: its result must never appear
    drive(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clock); @(negedge clock); end
    b32.flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    b32.flush = 1'b0;
    grab(1'b0);
    check("flush_valid", 64'(s_valid), 64'd0);
    check("flush_idle", 64'(s_hold), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      grab(1'b0);
      if (s_valid || s_hold) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);

    // Flush wins over a request offered in the same cycle
    drive(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
    b32.flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    b32.flush = 1'b0;
    drive(1'b0, 1'b0, 32'd5, 32'd0, 1'b0);
    grab(1'b0);
    check("flush_vs_valid", 64'(s_valid), 64'd0);
    @(posedge clock);
    @(negedge clock);
    grab(1'b0);
    check("flush_vs_valid2", 64'(s_valid), 64'd0);

    for (int i = 0; i < 40; i++) rand_op("rnd32", 1'b0);

    do_op(1'b1, 32'd1000, 32'd9, 1'b0, lat, holds);
    check("w16_q", 64'(s_q), 64'd111);
    check("w16_r", 64'(s_r), 64'd1);
    check("w16_lat", 64'(lat), 64'd5);
    check("w16_holds", 64'(holds), 64'd4);
    for (int i = 0; i < 30; i++) rand_op("rnd16", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised, multi-cycle, iterative integer divide unit for the execute stage.
- Replaces the fixed 32-bit combinational div/udiv pair and the hard-coded two-step divide delay counter.
- Accepts one request at a time with a valid/hold handshake, matching the pipeline flow-control convention.
- Produces quotient, remainder and status flags after a deterministic, parameter-dependent latency; supports signed and unsigned modes, flush and downstream stall.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4.
- BITS_PER_CYCLE, 1, quotient bits resolved per iteration cycle; WIDTH must be a multiple of it (checked by elaboration assertion).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present this cycle
- in_hold  out  1  unit cannot accept; upstream keeps request stable
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned
- numer  in  WIDTH  dividend
- denom  in  WIDTH  divisor
- flush  in  1  abort in-flight operation; discard result
- out_valid  out  1  result registers hold a valid result
- out_hold  in  1  downstream stall; result must stay stable
- quotient  out  WIDTH  quotient, truncated toward zero
- remainder  out  WIDTH  remainder; sign follows the dividend
- div_by_zero  out  1  denom was zero
- has_overflow  out  1  signed most-negative / -1, or div_by_zero

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; out_valid=0; quotient=0; remainder=0; div_by_zero=0; has_overflow=0; iteration counter=0.
- Held in reset mid-operation: all of the above values apply; the in-flight request is lost.
- FSM states: IDLE, RUN, DONE.
- in_hold is combinational: 1 in RUN; 1 in DONE while out_hold=1; otherwise 0.
- In IDLE with in_valid=1 and flush=0:
  - Latch |numer|, |denom| (magnitudes only when is_signed=1), quotient sign = numer[MSB]^denom[MSB], remainder sign = numer[MSB].
  - Special cases go straight to DONE with a one-cycle latency:
    - denom==0: quotient=all ones, remainder=numer, div_by_zero=1, has_overflow=1.
    - is_signed=1, numer==most-negative, denom==all ones: quotient=numer, remainder=0, has_overflow=1.
  - Otherwise go to RUN with counter=WIDTH/BITS_PER_CYCLE.
- RUN:
  - Each cycle performs BITS_PER_CYCLE restoring-division steps on a (2*WIDTH)-bit partial-remainder/quotient shift register and decrements the counter.
  - On counter reaching 1, apply the signs (two's-complement negate where required), register the results and go to DONE.
  - Total latency from accept to out_valid = WIDTH/BITS_PER_CYCLE + 1 cycles (33 for the defaults).
- DONE: out_valid=1.
  - out_hold=0: result is consumed this cycle. With in_valid=1 a new request is accepted in the same cycle (back-to-back); otherwise return to IDLE with out_valid=0 next cycle.
  - out_hold=1: all outputs frozen.
- flush=1 in any state: next state IDLE, out_valid=0, no request accepted that cycle. Flush has priority over in_valid and out_hold.
- Arithmetic: magnitudes use a WIDTH+1-bit subtractor, so unsigned operands with MSB=1 divide correctly. Results wrap to WIDTH bits.
- Inputs are sampled only on the accept edge; changes during RUN are ignored.

Decomposition:
- Shared package (alongside regval_t, regind_t, regfile_t):
  - enum div_state_t {IDLE, RUN, DONE}
  - typedef div_flags_t {div_by_zero, has_overflow}
  - function abs_val(value, is_signed)
  - function apply_sign(value, negate)
- One sub-module, div_step: purely combinational; one restoring step (partial remainder, divisor, incoming bit) -> (new partial remainder, quotient bit). Instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- Unsigned 100/7, WIDTH=32, BITS_PER_CYCLE=1 -> out_valid exactly 33 cycles after accept; quotient=14, remainder=2, flags 0; in_hold=1 for 32 cycles.
- Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
- 5/0 (either mode) -> one-cycle latency; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, has_overflow=1. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, has_overflow=1, div_by_zero=0.
- Result with out_hold=1 for 5 cycles -> outputs and out_valid stable, in_hold=1. Release with in_valid=1 (20/3) -> accepted the same cycle; next result quotient=6, remainder=2.
- flush at cycle 10 of RUN -> out_valid never asserted for that request; IDLE next cycle. Assert reset_n=0 mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
- BITS_PER_CYCLE=4, WIDTH=16: 1000/9 -> latency 5 cycles; quotient=111, remainder=1.
